id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined RV32I core, sitting directly upstream of the ALU. It registers decoded operands and controls from ID, resolves EX-stage operand forwarding from MEM and WB, detects load-use hazards and inserts bubbles, and drives the ALU's `A`, `B`, `ALUOp` and `PC` inputs plus the control bits that travel on to MEM.

---
 rtl/id_ex_stage.sv | 157 +++++++++++++++
 tb/tb_id_ex_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : ID/EX pipeline register for the RV32I core. Holds decoded
//             operands/controls, forwards MEM/WB results into the ALU
//             operands, detects load-use hazards and inserts bubbles.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    // ID-stage instruction
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_alu_op,
    input  logic            id_alusrc_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_is_branch,
    // Writeback candidates from later stages
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    // Pipeline control
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            id_stall,
    // EX-stage outputs
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_alu_a,
    output logic [XLEN-1:0] ex_alu_b,
    output logic [4:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_is_branch
);

    localparam logic [4:0] C_ALUOP_NOP = 5'b00000;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_alu_op;
    logic            r_alusrc_b;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_is_branch;

    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic            w_hz;
    logic            w_bubble;

    // Operand forwarding: MEM beats WB, x0 is never forwarded
    always_comb begin
        w_fwd_rs1 = r_rs1_val;
        w_fwd_rs2 = r_rs2_val;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == r_rs1))
            w_fwd_rs1 = mem_result;
        else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rs1))
            w_fwd_rs1 = wb_result;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == r_rs2))
            w_fwd_rs2 = mem_result;
        else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rs2))
            w_fwd_rs2 = wb_result;
    end

    // Load-use hazard against the load currently in EX; bubble selection
    always_comb begin
        w_hz = r_valid && r_mem_read && (r_rd != 5'd0) && id_valid &&
               ((id_use_rs1 && (id_rs1 == r_rd)) ||
                (id_use_rs2 && (id_rs2 == r_rd)));
        // Flush always kills; a hazard only bubbles when not frozen
        w_bubble = flush_i || (!stall_i && w_hz);
    end

    // Stage register: flush > stall (refresh operands) > hazard > load
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || w_bubble) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_alu_op    <= C_ALUOP_NOP;
            r_alusrc_b  <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_is_branch <= 1'b0;
        end else if (stall_i) begin
            // Capture forwarded values so a producer leaving WB is not lost
            r_rs1_val <= w_fwd_rs1;
            r_rs2_val <= w_fwd_rs2;
        end else begin
            r_valid     <= id_valid;
            r_pc        <= id_pc;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_rs1_val   <= id_rs1_data;
            r_rs2_val   <= id_rs2_data;
            r_imm       <= id_imm;
            r_alu_op    <= id_alu_op;
            r_alusrc_b  <= id_alusrc_b;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
            r_is_branch <= id_is_branch;
        end
    end

    // Output drive; controls gated by valid, stall forced low in reset
    always_comb begin
        id_stall      = rstn && (w_hz || stall_i);
        ex_valid      = r_valid;
        ex_pc         = r_pc;
        ex_alu_a      = w_fwd_rs1;
        ex_alu_b      = r_alusrc_b ? r_imm : w_fwd_rs2;
        ex_alu_op     = r_alu_op;
        ex_store_data = w_fwd_rs2;
        ex_rd         = r_rd;
        ex_reg_write  = r_valid && r_reg_write;
        ex_mem_read   = r_valid && r_mem_read;
        ex_mem_write  = r_valid && r_mem_write;
        ex_is_branch  = r_valid && r_is_branch;
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Brief    : Directed self-checking bench for id_ex_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam logic [4:0] C_ADD = 5'b00001;
    localparam logic [4:0] C_SUB = 5'b00011;

    logic            clk = 1'b0;
    logic            rstn;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_alu_op;
    logic            id_alusrc_b, id_reg_write, id_mem_read, id_mem_write, id_is_branch;
    logic [4:0]      mem_rd, wb_rd;
    logic            mem_reg_write, wb_reg_write;
    logic [XLEN-1:0] mem_result, wb_result;
    logic            stall_i, flush_i;
    logic            id_stall, ex_valid;
    logic [XLEN-1:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
    logic [4:0]      ex_alu_op, ex_rd;
    logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alusrc_b(id_alusrc_b),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_is_branch(id_is_branch),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .stall_i(stall_i), .flush_i(flush_i), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
        .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; checks happen 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] op, input logic srcb,
                          input logic rw, input logic mr, input logic mw, input logic br);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_alu_op = op; id_alusrc_b = srcb;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_is_branch = br;
    endtask

    task automatic clr_fwd();
        mem_rd = 5'd0; mem_reg_write = 1'b0; mem_result = '0;
        wb_rd  = 5'd0; wb_reg_write  = 1'b0; wb_result  = '0;
    endtask

    initial begin
        // ---------------- Reset state ----------------
        rstn = 1'b0; stall_i = 1'b1; flush_i = 1'b0;
        clr_fwd();
        set_id(1'b1, 32'h44, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7, C_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_id_stall", {31'd0, id_stall}, 32'd0);
        chk("rst_alu_op", {27'd0, ex_alu_op}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        stall_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // ---------------- Forwarding priority ----------------
        set_id(1'b1, 32'h100, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 32'h99, 32'h0, 32'h0, C_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        id_valid = 1'b0;
        mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h10;
        wb_rd  = 5'd5; wb_reg_write  = 1'b1; wb_result  = 32'h20;
        #1;
        chk("fwd_mem_prio", ex_alu_a, 32'h10);
        chk("fwd_pc", ex_pc, 32'h100);
        chk("fwd_reg_write", {31'd0, ex_reg_write}, 32'd1);
        mem_reg_write = 1'b0; #1;
        chk("fwd_wb", ex_alu_a, 32'h20);
        wb_reg_write = 1'b0; #1;
        chk("fwd_none", ex_alu_a, 32'h99);

        // ---------------- x0 never forwarded ----------------
        set_id(1'b1, 32'h104, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        id_valid = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'h10; wb_reg_write = 1'b0;
        #1;
        chk("x0_no_fwd", ex_alu_a, 32'h0);
        clr_fwd();

        // ---------------- Load-use hazard ----------------
        set_id(1'b1, 32'h108, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h4, C_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 32'h10C, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 32'hDEAD, 32'h0, 32'h1, C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_stall", {31'd0, id_stall}, 32'd1);
        chk("lu_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_op", {27'd0, ex_alu_op}, 32'd0);
        chk("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("lu_stall_released", {31'd0, id_stall}, 32'd0);
        tick();
        wb_rd = 5'd6; wb_reg_write = 1'b1; wb_result = 32'h55;
        #1;
        chk("lu_consumer_a", ex_alu_a, 32'h55);
        chk("lu_consumer_b", ex_alu_b, 32'h1);
        chk("lu_consumer_pc", ex_pc, 32'h10C);
        chk("lu_consumer_rd", {27'd0, ex_rd}, 32'd7);
        clr_fwd();
        // Consumer that does not read rs1 must not stall
        set_id(1'b1, 32'h110, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h4, C_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 32'h114, 5'd6, 5'd6, 5'd7, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1, C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_no_use_stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("lu_no_use_loaded", ex_pc, 32'h114);

        // ---------------- Stall capture ----------------
        set_id(1'b1, 32'h200, 5'd0, 5'd9, 5'd3, 1'b0, 1'b1, 32'h0, 32'h1111, 32'h8, C_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        wb_rd = 5'd9; wb_reg_write = 1'b1; wb_result = 32'hABCD;
        #1;
        chk("st_fwd_before", ex_store_data, 32'hABCD);
        stall_i = 1'b1;
        tick();
        wb_reg_write = 1'b0;
        #1;
        chk("st_data_c1", ex_store_data, 32'hABCD);
        chk("st_id_stall", {31'd0, id_stall}, 32'd1);
        tick();
        tick();
        chk("st_data_c3", ex_store_data, 32'hABCD);
        chk("st_pc_held", ex_pc, 32'h200);
        chk("st_mem_write_held", {31'd0, ex_mem_write}, 32'd1);
        chk("st_valid_held", {31'd0, ex_valid}, 32'd1);
        stall_i = 1'b0;
        clr_fwd();

        // ---------------- Flush beats hazard and stall ----------------
        set_id(1'b1, 32'h220, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 32'h224, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        stall_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("fl_id_stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_mem_read", {31'd0, ex_mem_read}, 32'd0);
        chk("fl_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("fl_alu_op", {27'd0, ex_alu_op}, 32'd0);
        stall_i = 1'b0; flush_i = 1'b0;
        set_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 32'h77, 32'h0, 32'h0, C_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("fl_next_valid", {31'd0, ex_valid}, 32'd1);
        chk("fl_next_pc", ex_pc, 32'h300);
        chk("fl_next_a", ex_alu_a, 32'h77);
        chk("fl_next_op", {27'd0, ex_alu_op}, {27'd0, C_SUB});
        chk("fl_next_branch", {31'd0, ex_is_branch}, 32'd1);

        // ---------------- Back-to-back + immediate select ----------------
        set_id(1'b1, 32'h304, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 32'h0, 32'h1, 32'hFFFFF800, C_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("b2b_pc", ex_pc, 32'h304);
        mem_rd = 5'd4; mem_reg_write = 1'b1; mem_result = 32'hCAFE;
        #1;
        chk("imm_alu_b", ex_alu_b, 32'hFFFFF800);
        chk("imm_store_data", ex_store_data, 32'hCAFE);

        // ---------------- Asynchronous reset mid-stream ----------------
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_alu_b", ex_alu_b, 32'd0);
        chk("arst_store", ex_store_data, 32'd0);
        chk("arst_mem_write", {31'd0, ex_mem_write}, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        clr_fwd();
        @(negedge clk);
        rstn = 1'b1;
        set_id(1'b1, 32'h400, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h3, C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_pc", ex_pc, 32'h400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety bound so the run always terminates
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
